// File: rtl/scan_score_display_if.sv
// scan_score_display_if: value in, multiplexed seven-segment drive out.
// master drives point; slave (the display block) drives the rest.
interface scan_score_display_if #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
);
  logic [VAL_W-1:0]  point;
  logic [7:0]        show;
  logic [DIGITS-1:0] ssd_ctrl;
  logic              busy;
  logic              ovf;

  modport master (
    output point,
    input  show, ssd_ctrl, busy, ovf
  );

  modport slave (
    input  point,
    output show, ssd_ctrl, busy, ovf
  );
endinterface

// File: rtl/scan_score_display.sv
// scan_score_display: double-dabble BCD conversion plus 7-seg digit scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module scan_score_display #(
  parameter int DIGITS   = 4,
  parameter int VAL_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input logic clk,
  input logic rst,
  scan_score_display_if.slave bus
);
  localparam int NB    = DIGITS + 1;
  localparam int BW    = NB * 4;
  localparam int DW    = DIGITS * 4;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t state, state_nx;

  logic [VAL_W-1:0]  cap;
  logic [VAL_W-1:0]  sh;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_adj;
  logic              lost;
  logic [CNT_W-1:0]  cnt;
  logic [DW-1:0]     disp;
  logic              ovf_r;
  logic [DIV_W-1:0]  div;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        show_r;
  logic [DIGITS-1:0] ctrl_r;
  logic [3:0]        nib;
  logic [7:0]        seg;
  logic              changed;
  logic              last_bit;
  logic              div_tc;

  assign changed  = (bus.point != cap);
  assign last_bit = (cnt == CNT_W'(VAL_W - 1));
  assign div_tc   = (div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (changed) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NB; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // lost catches bits pushed past the top guard nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      cap   <= '0;
      sh    <= '0;
      bcd   <= '0;
      lost  <= 1'b0;
      cnt   <= '0;
      disp  <= '0;
      ovf_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (changed) begin
            cap  <= bus.point;
            sh   <= bus.point;
            bcd  <= '0;
            lost <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          bcd  <= {bcd_adj[BW-2:0], sh[VAL_W-1]};
          lost <= lost | bcd_adj[BW-1];
          sh   <= {sh[VAL_W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
        end
        COMMIT: begin
          disp  <= bcd[DW-1:0];
          ovf_r <= lost | (|bcd[BW-1:DW]);
        end
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    enc = 8'h03;
      4'd1:    enc = 8'h9F;
      4'd2:    enc = 8'h25;
      4'd3:    enc = 8'h0D;
      4'd4:    enc = 8'h99;
      4'd5:    enc = 8'h49;
      4'd6:    enc = 8'h41;
      4'd7:    enc = 8'h1F;
      4'd8:    enc = 8'h01;
      4'd9:    enc = 8'h09;
      default: enc = 8'hFF;
    endcase
  endfunction

  assign nib = disp[idx*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zmask;
  logic              zacc;

  always_comb begin
    zmask = '0;
    zacc  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zacc     = zacc & (disp[k*4 +: 4] == 4'd0);
      zmask[k] = zacc;
    end
    zmask[0] = 1'b0;
  end

  always_comb begin
    seg = enc(nib);
    if (ovf_r)           seg = 8'hFD;
    else if (zmask[idx]) seg = 8'hFF;
  end
`else
  always_comb begin
    seg = enc(nib);
    if (ovf_r) seg = 8'hFD;
  end
`endif

  // outputs follow the index held before the edge, so digit 0
  // appears on the first edge after reset and each digit lasts SCAN_DIV
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      idx    <= '0;
      show_r <= 8'hFF;
      ctrl_r <= '1;
    end else begin
      div <= div_tc ? '0 : div + 1'b1;
      if (div_tc)
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      ctrl_r <= ~(DIGITS'(1) << idx);
      show_r <= seg;
    end
  end

  assign bus.show     = show_r;
  assign bus.ssd_ctrl = ctrl_r;
  assign bus.busy     = (state != IDLE);
  assign bus.ovf      = ovf_r;
endmodule
